fir_out_quant: RTL and testbench

- Downstream stage of the 3-tap transposed-form FIR.
- Consumes the full-precision 2*OPERAND_SIZE product-sum y, plus a per-sample valid that travels alongside x into the FIR.
- Suppresses pipeline warm-up outputs, then rounds and saturates each result to OUT_W bits.
- Buffers results in a small FIFO with a valid/ready interface to the next consumer.

---
 rtl/fir_out_quant_pkg.sv | 20 ++
 rtl/fir_out_quant_sync_fifo.sv | 83 ++++++++
 rtl/fir_out_quant.sv | 113 +++++++++++
 tb/tb_fir_out_quant.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fir_out_quant_pkg.sv
// rtl/fir_out_quant_pkg.sv - shared widths and defaults for the FIR and its output stage
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 16
`endif

package fir_out_quant_pkg;

   localparam int FIR_OPERAND_SIZE = `OPERAND_SIZE;
   localparam int FIR_IN_W         = 2 * FIR_OPERAND_SIZE;
   localparam int OUT_W_DEF        = 16;
   localparam int SHIFT_DEF        = 15;
   localparam int TAPS_DEF         = 3;
   localparam int DEPTH_DEF        = 4;

   typedef struct packed {
      logic sat;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/fir_out_quant_sync_fifo.sv
// rtl/fir_out_quant_sync_fifo.sv - power-of-two synchronous FIFO with flush and registered head
module fir_out_quant_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = dout_q;

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      // Head is registered from next-state memory so a write into an empty FIFO shows one cycle later; empty holds.
      dout_d = dout_q;
      if (count_d != '0) begin
         dout_d = mem_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/fir_out_quant.sv
// rtl/fir_out_quant.sv - FIR output stage: warm-up suppression, round/saturate, output FIFO
module fir_out_quant
   import fir_out_quant_pkg::*;
#(
   parameter int OPERAND_SIZE = FIR_OPERAND_SIZE,
   parameter int OUT_W        = OUT_W_DEF,
   parameter int SHIFT        = SHIFT_DEF,
   parameter int TAPS         = TAPS_DEF,
   parameter int DEPTH        = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*OPERAND_SIZE-1:0] y,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic                      clr_flags,
   output logic [OUT_W-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sat_flag,
   output logic                      ovf_flag
);

   localparam int IN_W   = 2 * OPERAND_SIZE;
   localparam int WARM_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(TAPS - 1);
   localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);
   localparam logic signed [IN_W:0] Q_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IN_W:0] Q_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

   flags_t              flags_q, flags_d;
   logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
   logic [IN_W:0]       t_u;
   logic signed [IN_W:0] q_s;
   logic [OUT_W-1:0]    q_out;
   logic                q_sat;
   logic                live;
   logic                push;
   logic                drop;
   logic                pop;
   logic                full;
   logic                empty;

   // One guard bit keeps the rounding add from wrapping at the positive extreme.
   always_comb begin
      t_u   = {y[IN_W-1], y} + RND;
      q_s   = $signed(t_u) >>> SHIFT;
      q_out = q_s[OUT_W-1:0];
      q_sat = 1'b0;
      if (q_s > Q_MAX) begin
         q_out = Q_MAX[OUT_W-1:0];
         q_sat = 1'b1;
      end else if (q_s < Q_MIN) begin
         q_out = Q_MIN[OUT_W-1:0];
         q_sat = 1'b1;
      end
   end

   always_comb begin
      live       = in_valid && !flush && (warm_cnt_q == WARM_MAX);
      push       = live && !full;
      drop       = live && full;
      pop        = out_valid && out_ready && !flush;
      warm_cnt_d = warm_cnt_q;
      if (flush) begin
         warm_cnt_d = '0;
      end else if (in_valid && (warm_cnt_q != WARM_MAX)) begin
         warm_cnt_d = warm_cnt_q + WARM_W'(1);
      end
      flags_d = flags_q;
      if (clr_flags) begin
         flags_d = '0;
      end
      if (push && q_sat) begin
         flags_d.sat = 1'b1;
      end
      if (drop) begin
         flags_d.ovf = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         warm_cnt_q <= '0;
         flags_q    <= '0;
      end else begin
         warm_cnt_q <= warm_cnt_d;
         flags_q    <= flags_d;
      end
   end

   fir_out_quant_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (q_out),
      .dout  (out_data),
      .full  (full),
      .empty (empty)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign sat_flag  = flags_q.sat;
   assign ovf_flag  = flags_q.ovf;

endmodule

// File: tb/tb_fir_out_quant.sv
// tb/tb_fir_out_quant.sv - directed self-checking bench for fir_out_quant
module tb_fir_out_quant;

   logic        clk;
   logic        rst;
   logic [31:0] y;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        clr_flags;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sat_flag;
   logic        ovf_flag;

   int n_checks = 0;
   int n_errors = 0;

   fir_out_quant dut (
      .clk       (clk),
      .rst       (rst),
      .y         (y),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .clr_flags (clr_flags),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag),
      .ovf_flag  (ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic live_sample(input string tag, input logic [31:0] yv, input logic [15:0] exp);
      y        = yv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp);
      tick();
   endtask

   initial begin
      rst = 1'b1; y = '0; in_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sat", sat_flag, 0);
      check("rst_ovf", ovf_flag, 0);
      rst = 1'b0;

      out_ready = 1'b1; y = 32'h0000_4000; in_valid = 1'b1;
      tick(); check("warm0_valid", out_valid, 0);
      tick(); check("warm1_valid", out_valid, 0);
      tick(); check("warm2_valid", out_valid, 1); check("warm2_data", out_data, 16'h0001);
      in_valid = 1'b0;
      tick(); check("warm_single_pulse", out_valid, 0); check("warm_hold_data", out_data, 16'h0001);

      live_sample("rnd_neg_half", 32'hFFFF_C000, 16'h0000);
      live_sample("rnd_below_half", 32'h0000_3FFF, 16'h0000);
      live_sample("rnd_up", 32'h0000_C000, 16'h0002);
      check("rnd_no_sat", sat_flag, 0);

      live_sample("sat_pos", 32'h4000_0000, 16'h7FFF);
      check("sat_pos_flag", sat_flag, 1);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      check("sat_clr", sat_flag, 0);
      live_sample("sat_neg", 32'h8000_0000, 16'h8000);
      check("sat_neg_flag", sat_flag, 1);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      live_sample("min_exact", 32'hC000_0000, 16'h8000);
      check("min_exact_no_sat", sat_flag, 0);

      clr_flags = 1'b1; y = 32'h4000_0000; in_valid = 1'b1;
      tick();
      clr_flags = 1'b0; in_valid = 1'b0;
      check("set_beats_clr", sat_flag, 1);
      check("set_beats_clr_data", out_data, 16'h7FFF);
      tick();
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      check("clr_both_sat", sat_flag, 0);
      check("clr_both_ovf", ovf_flag, 0);

      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         y = 32'(k) << 15; in_valid = 1'b1;
         tick();
         check($sformatf("bp_in_ready_%0d", k), in_ready, (k < 4) ? 1 : 0);
         check($sformatf("bp_ovf_%0d", k), ovf_flag, (k == 5) ? 1 : 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("drain_valid_%0d", k), out_valid, 1);
         check($sformatf("drain_data_%0d", k), out_data, k);
         tick();
      end
      check("drain_empty", out_valid, 0);

      out_ready = 1'b0; in_valid = 1'b1;
      y = 32'(10) << 15; tick();
      y = 32'(11) << 15; tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         y = 32'(12 + i) << 15;
         check($sformatf("conc_head_%0d", i), out_data, 10 + i);
         tick();
         check($sformatf("conc_in_ready_%0d", i), in_ready, 1);
         check($sformatf("conc_valid_%0d", i), out_valid, 1);
      end
      in_valid = 1'b0;
      check("conc_tail0", out_data, 20); tick();
      check("conc_tail1", out_data, 21); tick();
      check("conc_empty", out_valid, 0);

      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         y = 32'(k) << 15; in_valid = 1'b1; tick();
      end
      check("fl_pre_valid", out_valid, 1);
      flush = 1'b1; y = 32'(5) << 15; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", out_valid, 0);
      check("fl_in_ready", in_ready, 1);
      check("fl_ovf_kept", ovf_flag, 1);
      check("fl_data_hold", out_data, 16'h0001);
      y = 32'(7) << 15; in_valid = 1'b1;
      tick(); check("fl_warm0", out_valid, 0);
      tick(); check("fl_warm1", out_valid, 0);
      tick(); check("fl_live_valid", out_valid, 1); check("fl_live_data", out_data, 7);
      in_valid = 1'b0; tick();

      out_ready = 1'b0; y = 32'h4000_0000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("mid_sat", sat_flag, 1);
      check("mid_valid", out_valid, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_sat", sat_flag, 0);
      check("mid_rst_ovf", ovf_flag, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      out_ready = 1'b1; y = 32'h0000_4000; in_valid = 1'b1;
      tick(); check("re_warm0", out_valid, 0);
      tick(); check("re_warm1", out_valid, 0);
      tick(); check("re_live_valid", out_valid, 1); check("re_live_data", out_data, 16'h0001);
      in_valid = 1'b0; tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
